// File: rtl/psx_pad_emulator.sv
// PSX pad emulator on the controller side of the serial port.
// psx_clk/att/cmd are synchronised into clk and edge-detected. ack comes from a delay/width down-counter.
module psx_pad_emulator #(
  parameter int         NUM_DATA_BYTES = 2,
  parameter logic [3:0] ID_TYPE        = 4'h4,
  parameter int         ACK_DELAY      = 10,
  parameter int         ACK_WIDTH      = 4,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        psx_clk,
  input  logic                        att,
  input  logic                        cmd,
  input  logic [8*NUM_DATA_BYTES-1:0] pad_bytes,
  output logic                        data,
  output logic                        ack,
  output logic                        busy,
  output logic [7:0]                  rx_byte,
  output logic                        rx_valid,
  output logic                        frame_done
);
  // state  | meaning
  // IDLE   | waiting for att falling edge
  // SHIFT  | exchanging bytes with the console
  // IGNORE | frame not ours or finished; hold data/ack idle until att rises
  typedef enum logic [1:0] {IDLE, SHIFT, IGNORE} state_t;
  typedef enum logic [1:0] {ACK_OFF, ACK_WAIT, ACK_LOW} ack_st_t;

  localparam int N_BYTES = 3 + NUM_DATA_BYTES;
  localparam int CMAX    = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW      = $clog2(CMAX + 1);
  localparam logic [7:0] ID_BYTE = {ID_TYPE, 4'(NUM_DATA_BYTES / 2)};

  logic [SYNC_STAGES-1:0]      r_psx_sync, r_att_sync, r_cmd_sync;
  logic                        r_psx_d, r_att_d;
  state_t                      r_state;
  ack_st_t                     r_ack_st;
  logic [CW-1:0]               r_ack_cnt;
  logic [3:0]                  r_byte_idx;
  logic [2:0]                  r_bit_idx;
  logic [7:0]                  r_rx_sh, r_rx_byte;
  logic [8*NUM_DATA_BYTES-1:0] r_shadow;
  logic                        r_data, r_ack, r_busy, r_rx_valid, r_frame_done;

  logic       w_psx_s, w_att_s, w_cmd_s;
  logic       w_psx_rise, w_psx_fall, w_att_rise, w_att_fall;
  logic [7:0] w_rx_next, w_resp;

  // att chain resets low so a console already holding att low at release is not joined mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psx_sync <= '1;
      r_cmd_sync <= '1;
      r_att_sync <= '0;
      r_psx_d    <= 1'b1;
      r_att_d    <= 1'b0;
    end else begin
      r_psx_sync <= {r_psx_sync[SYNC_STAGES-2:0], psx_clk};
      r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], cmd};
      r_att_sync <= {r_att_sync[SYNC_STAGES-2:0], att};
      r_psx_d    <= r_psx_sync[SYNC_STAGES-1];
      r_att_d    <= r_att_sync[SYNC_STAGES-1];
    end
  end

  assign w_psx_s    = r_psx_sync[SYNC_STAGES-1];
  assign w_att_s    = r_att_sync[SYNC_STAGES-1];
  assign w_cmd_s    = r_cmd_sync[SYNC_STAGES-1];
  assign w_psx_rise = w_psx_s & ~r_psx_d;
  assign w_psx_fall = ~w_psx_s & r_psx_d;
  assign w_att_rise = w_att_s & ~r_att_d;
  assign w_att_fall = ~w_att_s & r_att_d;
  assign w_rx_next  = {w_cmd_s, r_rx_sh[7:1]};

  always_comb begin
    w_resp = 8'hFF;
    case (r_byte_idx)
      4'd0:    w_resp = 8'hFF;
      4'd1:    w_resp = ID_BYTE;
      4'd2:    w_resp = 8'h5A;
      default: begin
        for (int k = 0; k < NUM_DATA_BYTES; k++)
          if (r_byte_idx == 4'(k + 3)) w_resp = r_shadow[8*k +: 8];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ack_st     <= ACK_OFF;
      r_ack_cnt    <= '0;
      r_byte_idx   <= '0;
      r_bit_idx    <= '0;
      r_rx_sh      <= '0;
      r_rx_byte    <= '0;
      r_shadow     <= '0;
      r_data       <= 1'b1;
      r_ack        <= 1'b1;
      r_busy       <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_ack_st)
        ACK_WAIT: begin
          if (r_ack_cnt == '0) begin
            r_ack     <= 1'b0;
            r_ack_st  <= ACK_LOW;
            r_ack_cnt <= CW'(ACK_WIDTH - 1);
          end else begin
            r_ack_cnt <= r_ack_cnt - CW'(1);
          end
        end
        ACK_LOW: begin
          if (r_ack_cnt == '0) begin
            r_ack    <= 1'b1;
            r_ack_st <= ACK_OFF;
          end else begin
            r_ack_cnt <= r_ack_cnt - CW'(1);
          end
        end
        default: ;
      endcase

      // att rise takes priority over any psx_clk edge seen in the same cycle
      if (w_att_rise) begin
        r_state   <= IDLE;
        r_data    <= 1'b1;
        r_ack     <= 1'b1;
        r_busy    <= 1'b0;
        r_ack_st  <= ACK_OFF;
        r_ack_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_att_fall) begin
              r_shadow   <= pad_bytes;
              r_byte_idx <= '0;
              r_bit_idx  <= '0;
              r_busy     <= 1'b1;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_psx_fall) r_data <= w_resp[r_bit_idx];
            if (w_psx_rise) begin
              r_rx_sh   <= w_rx_next;
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_rx_byte  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_byte_idx <= r_byte_idx + 4'd1;
                if ((r_byte_idx == 4'd0 && w_rx_next != 8'h01) ||
                    r_byte_idx == 4'(N_BYTES - 1)) begin
                  r_frame_done <= (r_byte_idx == 4'(N_BYTES - 1));
                  r_state      <= IGNORE;
                  r_data       <= 1'b1;
                  r_ack        <= 1'b1;
                  r_ack_st     <= ACK_OFF;
                  r_ack_cnt    <= '0;
                end else begin
                  r_ack     <= 1'b1;
                  r_ack_st  <= ACK_WAIT;
                  r_ack_cnt <= CW'(ACK_DELAY - 1);
                end
              end
            end
          end
          default: begin
            r_data   <= 1'b1;
            r_ack    <= 1'b1;
            r_ack_st <= ACK_OFF;
          end
        endcase
      end
    end
  end

  assign data       = r_data;
  assign ack        = r_ack;
  assign busy       = r_busy;
  assign rx_byte    = r_rx_byte;
  assign rx_valid   = r_rx_valid;
  assign frame_done = r_frame_done;
endmodule

// File: doc/psx_pad_emulator.md
Name: psx_pad_emulator

Overview:
- Parametrised successor to the fake PSX controller. Emulates a PSX pad (digital or analog class) on the controller side of the serial port.
- All logic runs in one system clock domain. psx_clk, att and cmd are synchronised and edge-detected.
- ACK is timed by counters, not an RC network. The command stream is decoded and surfaced to the fabric.
- Button/axis bytes come from a live input bus rather than fixed parameters.

Parameters:
- NUM_DATA_BYTES, 2: payload bytes after 0x5A. Legal values 2, 4, 6 (even only).
- ID_TYPE, 4'h4: upper nibble of the ID byte. 4 = digital, 7 = analog. The lower nibble is NUM_DATA_BYTES/2.
- ACK_DELAY, 10: clk cycles from the detected 8th rising psx_clk of a byte to ack assertion. Minimum 1.
- ACK_WIDTH, 4: clk cycles ack is held low. Minimum 1.
- SYNC_STAGES, 2: flip-flop stages on each of psx_clk, att and cmd. Minimum 2.

Ports:
- clk  input  1  system clock; all state is on its rising edge
- rst  input  1  asynchronous reset, active high
- psx_clk  input  1  console serial clock; idle high, asynchronous
- att  input  1  console attention; active low, asynchronous
- cmd  input  1  console command line, LSB first, asynchronous
- pad_bytes  input  8*NUM_DATA_BYTES  payload; byte k at [8k+7:8k], each LSB first on the wire, 0 = pressed
- data  output  1  controller data line; 1 = released/idle
- ack  output  1  acknowledge, active low; 1 = idle
- busy  output  1  high while a transaction is active (synchronised att low)
- rx_byte  output  8  last command byte received
- rx_valid  output  1  one-clk pulse when rx_byte updates
- frame_done  output  1  one-clk pulse when the final byte of a frame addressed to us completes

Behaviour:
- Reset values: data=1, ack=1, busy=0, rx_byte=8'h00, rx_valid=0, frame_done=0, FSM=IDLE, all counters 0.
- Synchronisers: each input passes through SYNC_STAGES flops. One additional flop provides edge detection. Pin-to-detect latency is SYNC_STAGES+1 clk.
- Frame layout: N = 3 + NUM_DATA_BYTES bytes.
  - Response bytes: 8'hFF, {ID_TYPE, NUM_DATA_BYTES/2}, 8'h5A, then pad_bytes[0..NUM_DATA_BYTES-1].
  - pad_bytes is captured into a shadow register on the detected att falling edge. Later changes to pad_bytes do not affect the frame in progress.
- IDLE:
  - On att falling: load the shadow register, clear byte_idx and bit_idx, set busy=1, go to SHIFT.
- SHIFT:
  - On each detected psx_clk falling edge: data <= current response bit [byte_idx][bit_idx].
  - On each detected psx_clk rising edge: shift cmd into the receive register, bit_idx += 1 (3 bits, wraps).
  - When bit_idx wraps (8th rise):
    - rx_byte <= assembled byte, pulse rx_valid, byte_idx += 1.
  - Address check on byte 0: if the received byte != 8'h01, go to IGNORE. No ack is issued and data stays 1.
  - Otherwise, if byte_idx < N-1, start the ack timer.
  - If byte_idx == N-1 (last byte), pulse frame_done, issue no ack, go to IGNORE.
- Ack timer: runs independently of the shift FSM.
  - Wait ACK_DELAY clk, then hold ack=0 for ACK_WIDTH clk, then ack=1.
  - psx_clk edges arriving during the timer are still processed.
  - A new 8th-rise event while the timer is active restarts the timer.
- IGNORE:
  - data=1. psx_clk edges are ignored.
  - Any running ack timer is cancelled and ack=1.
  - Remain here until att rises.
- att rising in any state, including mid-byte or mid-ack:
  - Next clk after detection: FSM=IDLE, data=1, ack=1, busy=0.
  - Partial receive bits are discarded; no rx_valid or frame_done.
- Simultaneous att rise and psx_clk edge: the att rise wins.
- rx_byte is reported for every byte, including a non-0x01 byte 0.
- rst asserted mid-frame: all outputs return to their reset values immediately. Operation resumes at the next att falling edge after rst deasserts, even if att is already low at release; that partial frame is not joined.

Test Plan:
- Digital poll: default parameters, pad_bytes=16'hFF7F. Host sends 01 42 00 00 00 at 8 clk/half-bit. Data must read FF 41 5A 7F FF. Require exactly 4 ack pulses, each low 4 clk, starting 10 clk after the detected 8th rise. Require 5 rx_valid pulses with rx_byte 01,42,00,00,00 and one frame_done.
- Analog mode: NUM_DATA_BYTES=6, ID_TYPE=7, pad_bytes=48'h8080_7F7F_FFFE. Data must read FF 73 5A FE FF 7F 7F 80 80 with 8 acks.
- Wrong address: first cmd byte 8'h81. Data stays 1 for the whole frame. No ack and no frame_done. Require one rx_valid with rx_byte=8'h81.
- Abort: att rises after 3 bits of byte 2 while the ack timer is running. Within SYNC_STAGES+2 clk require ack=1, data=1, busy=0. A following full poll must succeed normally.
- Live-input isolation: change pad_bytes mid-frame. The frame must return the value captured at att fall; the next frame returns the new value.
- Reset: assert rst mid-ack. ack=1 and data=1 immediately. After rst deasserts the block stays idle until the next att fall.
